// File: rtl/f_fetch_unit.sv
// Instruction fetch stage: REQ/VALID/DISCARD handshake with instruction memory.
// Optional macro FETCH_BYPASS_EN forwards im_rdata straight to IR_F for one instruction per cycle.
module f_fetch_unit #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Stall,
  input  logic              Redirect,
  input  logic [DATA_W-1:0] Redirect_PC,
  output logic              im_req,
  output logic [DATA_W-1:0] im_addr,
  input  logic              im_ack,
  input  logic [DATA_W-1:0] im_rdata,
  output logic [DATA_W-1:0] IR_F,
  output logic [DATA_W-1:0] PC4_F
);

  typedef enum logic [1:0] {S_REQ, S_VALID, S_DISCARD} state_t;

  localparam logic [DATA_W-1:0] RESET_PC = DATA_W'(32'h0000_3000);
  localparam logic [DATA_W-1:0] STEP     = DATA_W'(4);

`ifdef FETCH_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  state_t            state;
  logic [DATA_W-1:0] pc;
  logic [DATA_W-1:0] ir_buf;
  logic [DATA_W-1:0] pc4_buf;
  logic [DATA_W-1:0] hold_addr;
  logic [DATA_W-1:0] pc_next4;

  assign pc_next4 = pc + STEP;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_REQ;
      pc        <= RESET_PC;
      ir_buf    <= '0;
      pc4_buf   <= RESET_PC + STEP;
      hold_addr <= RESET_PC;
    end else begin
      case (state)
        S_REQ: begin
          if (Redirect) begin
            pc <= Redirect_PC;
            // Request still in flight: keep presenting its address until the ack retires it.
            if (!im_ack) begin
              hold_addr <= pc;
              state     <= S_DISCARD;
            end
          end else if (im_ack) begin
            if (BYPASS && !Stall) begin
              pc <= pc_next4;
            end else begin
              ir_buf  <= im_rdata;
              pc4_buf <= pc_next4;
              state   <= S_VALID;
            end
          end
        end
        S_VALID: begin
          if (Redirect) begin
            pc    <= Redirect_PC;
            state <= S_REQ;
          end else if (!Stall) begin
            pc    <= pc_next4;
            state <= S_REQ;
          end
        end
        S_DISCARD: begin
          if (Redirect) pc <= Redirect_PC;
          if (im_ack) state <= S_REQ;
        end
        default: state <= S_REQ;
      endcase
    end
  end

  always_comb begin
    im_req  = reset && (state != S_VALID);
    im_addr = (state == S_DISCARD) ? hold_addr : pc;
    IR_F    = '0;
    PC4_F   = pc_next4;
    if (state == S_VALID) begin
      IR_F  = ir_buf;
      PC4_F = pc4_buf;
    end
`ifdef FETCH_BYPASS_EN
    else if (state == S_REQ && reset && im_ack && !Redirect && !Stall) begin
      IR_F = im_rdata;
    end
`endif
  end

endmodule
